// File: rtl/uart_rx_frame_buf_pkg.sv
// Shared state encoding, parameter defaults and debug-probe field offsets
// for the UART RX frame assembler.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned DEF_ADDR_W  = 10;
  localparam logic [7:0]  DEF_DELIM   = 8'h0D;
  localparam int unsigned DEF_TO_W    = 16;
  localparam int unsigned DEF_IDLE_TO = 43400;

  // o_probe = {state[1:0], len[10:0], timer[15:0], drop[7:0], err, wen, wdone}
  localparam int unsigned PROBE_W   = 40;
  localparam int unsigned PRB_WDONE = 0;
  localparam int unsigned PRB_WEN   = 1;
  localparam int unsigned PRB_ERR   = 2;
  localparam int unsigned PRB_DROP  = 3;
  localparam int unsigned PRB_TIMER = 11;
  localparam int unsigned PRB_LEN   = 27;
  localparam int unsigned PRB_STATE = 38;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_rx_frame_buf_if.sv
// Byte-receiver input, TX release strobe and RX-memory port A write side of
// the frame assembler; slave = assembler, master = its environment.
interface uart_rx_frame_buf_if
  import uart_frame_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              i_rx_valid;
  logic [7:0]        i_rx_data;
  logic              i_rx_err;
  logic              i_rx_mem_rdone;

  logic              o_rx_mem_en;
  logic              o_rx_mem_wen;
  logic [ADDR_W-1:0] o_rx_mem_waddr;
  logic [7:0]        o_rx_mem_wdata;
  logic              o_rx_mem_wdone;
  logic [ADDR_W:0]   o_rx_len;
  logic              o_rx_err;
  logic [7:0]        o_drop_cnt;
  logic [PROBE_W-1:0] o_probe;

  modport master (
    output i_rx_valid, i_rx_data, i_rx_err, i_rx_mem_rdone,
    input  o_rx_mem_en, o_rx_mem_wen, o_rx_mem_waddr, o_rx_mem_wdata,
    input  o_rx_mem_wdone, o_rx_len, o_rx_err, o_drop_cnt, o_probe
  );

  modport slave (
    input  i_rx_valid, i_rx_data, i_rx_err, i_rx_mem_rdone,
    output o_rx_mem_en, o_rx_mem_wen, o_rx_mem_waddr, o_rx_mem_wdata,
    output o_rx_mem_wdone, o_rx_len, o_rx_err, o_drop_cnt, o_probe
  );

endinterface

// File: rtl/uart_rx_frame_buf_timer.sv
// Idle timer: cleared by clr, counts while en, saturates at IDLE_TO-1 and
// flags expire in the cycle it sits at that terminal count.
module uart_idle_timer #(
  parameter int unsigned TO_W    = 16,
  parameter int unsigned IDLE_TO = 43400
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  output logic [TO_W-1:0] cnt,
  output logic            expire
);

  localparam logic [TO_W-1:0] TC = TO_W'(IDLE_TO - 1);

  assign expire = en && !clr && (cnt == TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != TC)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame_buf.sv
// Frame assembler: writes received bytes to RX memory, closes on delimiter, idle timeout or full,
// then holds the buffer until TX releases it. `RX_DELIM_STORE_EN also stores the delimiter byte.
module uart_rx_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter logic [7:0]  DELIM   = DEF_DELIM,
  parameter int unsigned TO_W    = DEF_TO_W,
  parameter int unsigned IDLE_TO = DEF_IDLE_TO
) (
  input logic               i_clk,
  input logic               i_reset,
  uart_rx_frame_buf_if.slave bus
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   len;
  logic              err;
  logic [7:0]        drop;
  logic              mem_en;
  logic              mem_wen;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic              wdone;

  logic [TO_W-1:0]   timer;
  logic              expire;

  logic              err_byte;
  logic              data_byte;
  logic              delim_byte;
  logic              start;
  logic [ADDR_W:0]   count_inc;

  assign err_byte   = bus.i_rx_valid && bus.i_rx_err;
  assign data_byte  = bus.i_rx_valid && !bus.i_rx_err;
  assign delim_byte = data_byte && (bus.i_rx_data == DELIM);
  assign count_inc  = count + 1'b1;

  // A release in HOLD makes this cycle behave like IDLE, so a coincident byte opens the next frame.
  assign start = (state == IDLE) || ((state == HOLD) && bus.i_rx_mem_rdone);

  uart_idle_timer #(
    .TO_W    (TO_W),
    .IDLE_TO (IDLE_TO)
  ) u_idle_timer (
    .clk    (i_clk),
    .rst_n  (i_reset),
    .clr    (bus.i_rx_valid || (state != RECV)),
    .en     (state == RECV),
    .cnt    (timer),
    .expire (expire)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      count   <= '0;
      len     <= '0;
      err     <= 1'b0;
      drop    <= '0;
      mem_en  <= 1'b0;
      mem_wen <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      wdone   <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      mem_wen <= 1'b0;
      wdone   <= 1'b0;
      if (start) begin
        if (err_byte) begin
          state <= RECV;
          count <= '0;
          err   <= 1'b1;
          drop  <= '0;
        end else if (data_byte && !delim_byte) begin
          state   <= RECV;
          count   <= {{ADDR_W{1'b0}}, 1'b1};
          err     <= 1'b0;
          drop    <= '0;
          mem_en  <= 1'b1;
          mem_wen <= 1'b1;
          waddr   <= '0;
          wdata   <= bus.i_rx_data;
        end else begin
          state <= IDLE;
        end
      end else if (state == RECV) begin
        if (err_byte) begin
          err <= 1'b1;
        end else if (delim_byte) begin
`ifdef RX_DELIM_STORE_EN
          mem_en  <= 1'b1;
          mem_wen <= 1'b1;
          waddr   <= count[ADDR_W-1:0];
          wdata   <= bus.i_rx_data;
          count   <= count_inc;
          len     <= count_inc;
`else
          len     <= count;
`endif
          wdone <= 1'b1;
          state <= HOLD;
        end else if (data_byte) begin
          mem_en  <= 1'b1;
          mem_wen <= 1'b1;
          waddr   <= count[ADDR_W-1:0];
          wdata   <= bus.i_rx_data;
          count   <= count_inc;
          if (count_inc == FULL) begin
            len   <= FULL;
            wdone <= 1'b1;
            state <= HOLD;
          end
        end else if (expire) begin
          len   <= count;
          wdone <= 1'b1;
          state <= HOLD;
        end
      end else if (state == HOLD) begin
        if (bus.i_rx_valid) begin
          drop <= sat_inc8(drop);
        end
      end else begin
        state <= IDLE;
      end
    end
  end

  assign bus.o_rx_mem_en    = mem_en;
  assign bus.o_rx_mem_wen   = mem_wen;
  assign bus.o_rx_mem_waddr = waddr;
  assign bus.o_rx_mem_wdata = wdata;
  assign bus.o_rx_mem_wdone = wdone;
  assign bus.o_rx_len       = len;
  assign bus.o_rx_err       = err;
  assign bus.o_drop_cnt     = drop;

  always_comb begin
    bus.o_probe                  = '0;
    bus.o_probe[PRB_STATE +: 2]  = state;
    bus.o_probe[PRB_LEN +: 11]   = 11'(len);
    bus.o_probe[PRB_TIMER +: 16] = 16'(timer);
    bus.o_probe[PRB_DROP +: 8]   = drop;
    bus.o_probe[PRB_ERR]         = err;
    bus.o_probe[PRB_WEN]         = mem_wen;
    bus.o_probe[PRB_WDONE]       = wdone;
  end

endmodule

// File: tb/tb_uart_rx_frame_buf.sv
// Directed bench for uart_rx_frame_buf: delimiter, timeout, full, HOLD drops,
// error bytes and mid-frame reset, with hand-computed expectations.
module tb_uart_rx_frame_buf;
  import uart_frame_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int TO    = 43400;
`ifdef RX_DELIM_STORE_EN
  localparam int DS = 1;
`else
  localparam int DS = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  uart_rx_frame_buf_if #(.ADDR_W(AW)) bus ();

  uart_rx_frame_buf #(
    .ADDR_W  (AW),
    .DELIM   (8'h0D),
    .TO_W    (16),
    .IDLE_TO (TO)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wr_total = 0;
  int wd_total = 0;
  int wd_cyc   = 0;
  logic [7:0] mem_img [DEPTH];

  always @(posedge clk) cyc++;

  // Passive view of memory port A and the frame-done strobe.
  always @(negedge clk) begin
    if (bus.o_rx_mem_wen) begin
      wr_total++;
      mem_img[bus.o_rx_mem_waddr] = bus.o_rx_mem_wdata;
    end
    if (bus.o_rx_mem_wdone) begin
      wd_total++;
      wd_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic e);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = d;
    bus.i_rx_err   = e;
    tick();
    bus.i_rx_valid = 1'b0;
    bus.i_rx_err   = 1'b0;
  endtask

  task automatic release_buf();
    bus.i_rx_mem_rdone = 1'b1;
    tick();
    bus.i_rx_mem_rdone = 1'b0;
  endtask

  // Fill pattern for the full-buffer test; 0x0D would close the frame early, so it is replaced.
  function automatic logic [7:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (b == 8'h0D) ? 8'hEE : b;
  endfunction

  function automatic logic [1:0] st();
    return bus.o_probe[39:38];
  endfunction

  initial begin
    int base_wr;
    int base_wd;
    int z_cyc;
    int bad;

    bus.i_rx_valid     = 1'b0;
    bus.i_rx_data      = 8'h00;
    bus.i_rx_err       = 1'b0;
    bus.i_rx_mem_rdone = 1'b0;
    repeat (3) tick();

    check("rst_en",    bus.o_rx_mem_en, 0);
    check("rst_wen",   bus.o_rx_mem_wen, 0);
    check("rst_waddr", bus.o_rx_mem_waddr, 0);
    check("rst_wdata", bus.o_rx_mem_wdata, 0);
    check("rst_wdone", bus.o_rx_mem_wdone, 0);
    check("rst_len",   bus.o_rx_len, 0);
    check("rst_err",   bus.o_rx_err, 0);
    check("rst_drop",  bus.o_drop_cnt, 0);
    check("rst_probe", bus.o_probe, 0);
    rst_n = 1'b1;
    tick();

    // 1: "AB" + delimiter
    send(8'h41, 1'b0);
    check("t1_wen0",   bus.o_rx_mem_wen, 1);
    check("t1_addr0",  bus.o_rx_mem_waddr, 0);
    check("t1_data0",  bus.o_rx_mem_wdata, 8'h41);
    check("t1_recv",   st(), RECV);
    send(8'h42, 1'b0);
    check("t1_addr1",  bus.o_rx_mem_waddr, 1);
    check("t1_data1",  bus.o_rx_mem_wdata, 8'h42);
    send(8'h0D, 1'b0);
    check("t1_wdone",  bus.o_rx_mem_wdone, 1);
    check("t1_len",    bus.o_rx_len, 2 + DS);
    check("t1_dwen",   bus.o_rx_mem_wen, DS);
`ifdef RX_DELIM_STORE_EN
    check("t1_daddr",  bus.o_rx_mem_waddr, 2);
    check("t1_ddata",  bus.o_rx_mem_wdata, 8'h0D);
`endif
    tick();
    check("t1_pulse",  bus.o_rx_mem_wdone, 0);
    check("t1_hold",   st(), HOLD);
    check("t1_lenhld", bus.o_rx_len, 2 + DS);
    send(8'h77, 1'b0);
    check("t1_drop",   bus.o_drop_cnt, 1);
    check("t1_nowr",   bus.o_rx_mem_wen, 0);
    release_buf();
    check("t1_idle",   st(), IDLE);

    // 2: "XYZ" then silence until the idle timeout closes the frame
    base_wr = wr_total;
    send(8'h58, 1'b0);
    check("t2_dropclr", bus.o_drop_cnt, 0);
    send(8'h59, 1'b0);
    send(8'h5A, 1'b0);
    z_cyc   = cyc;
    base_wd = wd_total;
    for (int i = 0; i < TO + 20 && wd_total == base_wd; i++) tick();
    check("t2_wdone_seen", wd_total - base_wd, 1);
    check("t2_latency",    wd_cyc - z_cyc, TO);
    check("t2_len",        bus.o_rx_len, 3);
    check("t2_writes",     wr_total - base_wr, 3);
    check("t2_hold",       st(), HOLD);
    release_buf();

    // 3: fill all DEPTH bytes; the last write and wdone coincide
    base_wr = wr_total;
    for (int i = 0; i < DEPTH; i++) begin
      send(pat(i), 1'b0);
      if (i == DEPTH - 2) begin
        check("t3_notyet", bus.o_rx_mem_wdone, 0);
        check("t3_recv",   st(), RECV);
      end
    end
    check("t3_wen",    bus.o_rx_mem_wen, 1);
    check("t3_addr",   bus.o_rx_mem_waddr, DEPTH - 1);
    check("t3_data",   bus.o_rx_mem_wdata, pat(DEPTH - 1));
    check("t3_wdone",  bus.o_rx_mem_wdone, 1);
    check("t3_len",    bus.o_rx_len, DEPTH);
    check("t3_hold",   st(), HOLD);
    tick();
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (mem_img[a] !== pat(a)) bad++;
    check("t3_image",  bad, 0);
    check("t3_writes", wr_total - base_wr, DEPTH);
    send(8'h00, 1'b0);
    check("t3_drop1",  bus.o_drop_cnt, 1);
    check("t3_nowr",   bus.o_rx_mem_wen, 0);

    // 4: drop counter saturation, then release with a coincident byte
    for (int i = 0; i < 299; i++) send(8'(i), 1'b0);
    check("t4_dropsat", bus.o_drop_cnt, 255);
    check("t4_writes",  wr_total - base_wr, DEPTH);
    bus.i_rx_mem_rdone = 1'b1;
    bus.i_rx_valid     = 1'b1;
    bus.i_rx_data      = 8'h55;
    tick();
    bus.i_rx_mem_rdone = 1'b0;
    bus.i_rx_valid     = 1'b0;
    check("t4_wen",     bus.o_rx_mem_wen, 1);
    check("t4_addr",    bus.o_rx_mem_waddr, 0);
    check("t4_data",    bus.o_rx_mem_wdata, 8'h55);
    check("t4_dropclr", bus.o_drop_cnt, 0);
    check("t4_recv",    st(), RECV);
    send(8'h0D, 1'b0);
    check("t4_len",     bus.o_rx_len, 1 + DS);
    release_buf();

    // 5: error byte (delimiter value, flagged bad) between 'A' and 'B'
    base_wr = wr_total;
    send(8'h41, 1'b0);
    send(8'h0D, 1'b1);
    check("t5_err",    bus.o_rx_err, 1);
    check("t5_open",   st(), RECV);
    check("t5_nowr",   bus.o_rx_mem_wen, 0);
    send(8'h42, 1'b0);
    check("t5_addr",   bus.o_rx_mem_waddr, 1);
    send(8'h0D, 1'b0);
    check("t5_wdone",  bus.o_rx_mem_wdone, 1);
    check("t5_errwd",  bus.o_rx_err, 1);
    check("t5_len",    bus.o_rx_len, 2 + DS);
    tick();
    check("t5_writes", wr_total - base_wr, 2 + DS);
    release_buf();
    send(8'h43, 1'b0);
    check("t5_errclr", bus.o_rx_err, 0);
    check("t5_naddr",  bus.o_rx_mem_waddr, 0);

    // 6: stray release in RECV, then asynchronous reset after 5 bytes
    release_buf();
    check("t6_rdign",  st(), RECV);
    send(8'h44, 1'b0);
    send(8'h45, 1'b0);
    send(8'h46, 1'b0);
    send(8'h47, 1'b0);
    check("t6_addr4",  bus.o_rx_mem_waddr, 4);
    base_wd = wd_total;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rwen",   bus.o_rx_mem_wen, 0);
    check("t6_ren",    bus.o_rx_mem_en, 0);
    check("t6_raddr",  bus.o_rx_mem_waddr, 0);
    check("t6_rdata",  bus.o_rx_mem_wdata, 0);
    check("t6_rlen",   bus.o_rx_len, 0);
    check("t6_rprobe", bus.o_probe, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("t6_nowd",   wd_total - base_wd, 0);
    send(8'h0D, 1'b0);
    check("t6_zlen",   st(), IDLE);
    check("t6_zwd",    bus.o_rx_mem_wdone, 0);
    send(8'h11, 1'b1);
    check("t6_errst",  st(), RECV);
    check("t6_errset", bus.o_rx_err, 1);
    send(8'h51, 1'b0);
    check("t6_addr",   bus.o_rx_mem_waddr, 0);
    check("t6_data",   bus.o_rx_mem_wdata, 8'h51);
    send(8'h0D, 1'b0);
    check("t6_wdone",  bus.o_rx_mem_wdone, 1);
    check("t6_len",    bus.o_rx_len, 1 + DS);
    tick();
    check("t6_wdcnt",  wd_total - base_wd, 1);
    release_buf();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
